// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA output stage.
package vga_pkg;

  typedef logic [23:0] rgb_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, raster counters and the combinational decode of the
// counter position (active region, sync pulses, frame origin and end).
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic pix_en,
  output logic active,
  output logic origin,
  output logic hs_n,
  output logic vs_n,
  output logic frame_end,
  output logic vga_clk
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit so a sync pulse ending exactly at the total still fits.
  localparam int HW = $clog2(H_TOT) + 1;
  localparam int VW = $clog2(V_TOT) + 1;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  always_comb begin
    div_nxt = '0;
    if (enable && (div != DIV_LAST)) div_nxt = div + DW'(1);
  end

  // vga_clk is registered from the next divider value so it is low for the
  // first half of each pixel and rises mid-pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_nxt;
      vga_clk <= (div_nxt >= DIV_HALF);
    end
  end

  assign pix_en = enable && (div == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign origin    = (h_cnt == '0) && (v_cnt == '0);
  assign hs_n      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign frame_end = pix_en && h_last && v_last;

endmodule

// File: rtl/vga_out_stage.sv
// Final VGA pixel stage: locks the incoming RGB stream to the raster, drives
// the registered board pins and counts underflow/misalign events and frames.
module vga_out_stage
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [23:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [15:0] underflow_cnt,
  output logic [15:0] frame_cnt,
  output state_t      fsm_state
);

  logic   pix_en;
  logic   active;
  logic   origin;
  logic   hs_n;
  logic   vs_n;
  logic   frame_end;
  state_t state;
  state_t state_nxt;
  logic   take;
  logic   fault;
  rgb_t   rgb_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pix_en    (pix_en),
    .active    (active),
    .origin    (origin),
    .hs_n      (hs_n),
    .vs_n      (vs_n),
    .frame_end (frame_end),
    .vga_clk   (vga_clk)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC_WAIT;
    else          state <= state_nxt;
  end

  // Handshake: a pixel transfers on a cycle where pix_valid && pix_ready;
  // pix_ready depends only on registered state/counters and the offered
  // valid/sof, never on pix_data. While unsynchronised, non-sof pixels are
  // drained immediately and a sof pixel is held until the raster origin.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    take      = 1'b0;
    fault     = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (pix_valid && !pix_sof) begin
          pix_ready = 1'b1;
        end else if (pix_valid && pix_sof && pix_en && origin) begin
          pix_ready = 1'b1;
          take      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (pix_en && active) begin
          if (pix_valid && (pix_sof == origin)) begin
            pix_ready = 1'b1;
            take      = 1'b1;
          end else begin
            // Underflow keeps ready high; a misaligned pixel is left unconsumed.
            pix_ready = !pix_valid;
            fault     = 1'b1;
            state_nxt = SYNC_WAIT;
          end
        end
      end
      default: state_nxt = SYNC_WAIT;
    endcase
    if (!enable) state_nxt = SYNC_WAIT;
  end

  // Pins are registered on pix_en from the current position, so every pin
  // shows the same (previous) pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q         <= '0;
      vga_hs        <= 1'b1;
      vga_vs        <= 1'b1;
      vga_blank_n   <= 1'b0;
      underflow_cnt <= '0;
      frame_cnt     <= '0;
    end else if (!enable) begin
      rgb_q         <= '0;
      vga_hs        <= 1'b1;
      vga_vs        <= 1'b1;
      vga_blank_n   <= 1'b0;
      underflow_cnt <= '0;
      frame_cnt     <= '0;
    end else if (pix_en) begin
      rgb_q       <= take ? pix_data : '0;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_blank_n <= active;
      if (fault && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_sync_n = 1'b0;
  assign fsm_state  = state;

endmodule

// File: tb/tb_vga_out_stage.sv
// Bench for vga_out_stage on a tiny 8x6 raster: a cycle-level stream model
// predicts ready, pins and status counters for randomized pixel streams.
module tb_vga_out_stage;
  import vga_pkg::*;

  localparam int H_ACTIVE = 4;
  localparam int H_FP     = 1;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 3;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int CLK_DIV  = 2;
  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CYC = H_TOT * V_TOT * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [15:0] underflow_cnt, frame_cnt;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
  } item_t;

  item_t       src_q[$];
  logic [23:0] exp_q[$];

  // Reference model state: cycles since enable, lock status, expected pins.
  int          cyc;
  bit          synced;
  logic [23:0] exp_rgb;
  logic        exp_hs, exp_vs, exp_blank;
  int          exp_uf, exp_fc;
  int          gap_lo, gap_hi;
  bit          bubbles;

  always #5 clk = ~clk;

  vga_out_stage #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_clk       (vga_clk),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_blank_n   (vga_blank_n),
    .vga_sync_n    (vga_sync_n),
    .underflow_cnt (underflow_cnt),
    .frame_cnt     (frame_cnt),
    .fsm_state     (fsm_state)
  );

  function automatic void model_init();
    cyc       = 0;
    synced    = 1'b0;
    exp_rgb   = '0;
    exp_hs    = 1'b1;
    exp_vs    = 1'b1;
    exp_blank = 1'b0;
    exp_uf    = 0;
    exp_fc    = 0;
    exp_q.delete();
  endfunction

  function automatic int slot_cyc(int frame, int x, int y);
    return CLK_DIV * (frame * H_TOT * V_TOT + y * H_TOT + x) + CLK_DIV - 1;
  endfunction

  function automatic void push_frame(bit rnd, logic [23:0] base, int extra_sof);
    item_t it;
    for (int i = 0; i < H_ACTIVE * V_ACTIVE; i++) begin
      it.data = rnd ? 24'($urandom) : base + 24'(i);
      it.sof  = (i == 0) || (i == extra_sof);
      src_q.push_back(it);
    end
  endfunction

  // One clock: drive the source, predict the slot outcome, check ready, then
  // check pins and status just after the edge.
  task automatic step();
    int          k, x, y;
    bit          pix, org, act, hold, exp_ready, exp_clk;
    logic [23:0] shown;
    logic [4:0]  got_pins, want_pins;
    pix  = (cyc % CLK_DIV) == CLK_DIV - 1;
    k    = cyc / CLK_DIV;
    x    = k % H_TOT;
    y    = (k / H_TOT) % V_TOT;
    org  = (x == 0) && (y == 0);
    act  = (x < H_ACTIVE) && (y < V_ACTIVE);
    hold = (cyc >= gap_lo && cyc < gap_hi) || (bubbles && !pix && $urandom_range(0, 2) == 0);
    if (src_q.size() > 0 && !hold) begin
      pix_valid = 1'b1;
      pix_data  = src_q[0].data;
      pix_sof   = src_q[0].sof;
    end else begin
      pix_valid = 1'b0;
      pix_data  = 24'($urandom);
      pix_sof   = 1'($urandom_range(0, 1));
    end
    #1;
    exp_ready = 1'b0;
    shown     = '0;
    if (!synced) begin
      if (pix_valid && !pix_sof) exp_ready = 1'b1;
      else if (pix_valid && pix_sof && pix && org) begin
        exp_ready = 1'b1;
        shown     = pix_data;
        synced    = 1'b1;
      end
    end else if (pix && act) begin
      if (!pix_valid) begin
        exp_ready = 1'b1;
        synced    = 1'b0;
        if (exp_uf < 65535) exp_uf++;
      end else if (pix_sof != org) begin
        synced = 1'b0;
        if (exp_uf < 65535) exp_uf++;
      end else begin
        exp_ready = 1'b1;
        shown     = pix_data;
      end
    end
    checks++;
    if (pix_ready !== exp_ready) begin
      errors++;
      $display("FAIL ready cyc=%0d got=%b want=%b", cyc, pix_ready, exp_ready);
    end
    if (pix_valid && exp_ready) void'(src_q.pop_front());
    if (pix) begin
      exp_q.push_back(shown);
      exp_hs    = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
      exp_vs    = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
      exp_blank = act;
      if (x == H_TOT - 1 && y == V_TOT - 1) exp_fc++;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (pix) exp_rgb = exp_q.pop_front();
    exp_clk = (cyc % CLK_DIV) >= (CLK_DIV / 2);
    checks++;
    if ({vga_r, vga_g, vga_b} !== exp_rgb) begin
      errors++;
      $display("FAIL rgb cyc=%0d got=%h want=%h", cyc, {vga_r, vga_g, vga_b}, exp_rgb);
    end
    got_pins  = {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk};
    want_pins = {exp_hs, exp_vs, exp_blank, 1'b0, exp_clk};
    checks++;
    if (got_pins !== want_pins) begin
      errors++;
      $display("FAIL pins(hs,vs,blank_n,sync_n,clk) cyc=%0d got=%b want=%b", cyc, got_pins, want_pins);
    end
    checks++;
    if ({underflow_cnt, frame_cnt} !== {16'(exp_uf), 16'(exp_fc)}) begin
      errors++;
      $display("FAIL status cyc=%0d got uf=%0d fc=%0d want uf=%0d fc=%0d",
               cyc, underflow_cnt, frame_cnt, exp_uf, exp_fc);
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic start_stream();
    enable    = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    gap_lo    = -1;
    gap_hi    = -1;
    bubbles   = 1'b0;
    src_q.delete();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b1;
    model_init();
  endtask

  task automatic check_idle_pins(string name);
    checks++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk} !== {24'h0, 5'b11000}) begin
      errors++;
      $display("FAIL %s pins got rgb=%h hs=%b vs=%b blank_n=%b sync_n=%b clk=%b want rgb=0 hs=1 vs=1 others 0",
               name, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk);
    end
    checks++;
    if ({underflow_cnt, frame_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL %s counters got uf=%0d fc=%0d want 0", name, underflow_cnt, frame_cnt);
    end
    checks++;
    if (fsm_state !== SYNC_WAIT) begin
      errors++;
      $display("FAIL %s state got=%0d want=SYNC_WAIT", name, fsm_state);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_pins("reset");
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, blank_hi = 0;
    start_stream();
    for (int i = 0; i < FRAME_CYC; i++) begin
      step();
      if (vga_hs === 1'b0) hs_low++;
      if (vga_vs === 1'b0) vs_low++;
      if (vga_blank_n === 1'b1) blank_hi++;
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL timing_frame_cnt got=%0d want=1", frame_cnt);
    end
    checks++;
    if ({hs_low, vs_low, blank_hi} !== {32'd24, 32'd16, 32'd24}) begin
      errors++;
      $display("FAIL timing_counts got hs_low=%0d vs_low=%0d blank_hi=%0d want 24 16 24", hs_low, vs_low, blank_hi);
    end
    run(FRAME_CYC / 2);
  endtask

  task automatic test_normal_frame();
    start_stream();
    push_frame(1'b0, 24'h000001, -1);
    push_frame(1'b1, 24'h0, -1);
    bubbles = 1'b1;
    run(2 * FRAME_CYC);
    checks++;
    if (underflow_cnt !== 16'd0) begin
      errors++;
      $display("FAIL normal_underflow got=%0d want=0", underflow_cnt);
    end
  endtask

  task automatic test_underflow();
    start_stream();
    push_frame(1'b0, 24'h000100, -1);
    push_frame(1'b1, 24'h0, -1);
    gap_lo = slot_cyc(0, 0, 1);
    gap_hi = gap_lo + 1;
    run(2 * FRAME_CYC);
    checks++;
    if (underflow_cnt !== 16'd1) begin
      errors++;
      $display("FAIL underflow_cnt got=%0d want=1", underflow_cnt);
    end
  endtask

  task automatic test_misalign();
    item_t it;
    start_stream();
    push_frame(1'b0, 24'h000200, 2);
    for (int i = 0; i < 2; i++) begin
      it.data = 24'($urandom);
      it.sof  = 1'b0;
      src_q.push_back(it);
    end
    push_frame(1'b1, 24'h0, -1);
    run(3 * FRAME_CYC);
    checks++;
    if (underflow_cnt !== 16'd1) begin
      errors++;
      $display("FAIL misalign_cnt got=%0d want=1", underflow_cnt);
    end
  endtask

  task automatic test_sync_drop();
    item_t it;
    start_stream();
    for (int i = 0; i < 3; i++) begin
      it.data = 24'($urandom);
      it.sof  = 1'b0;
      src_q.push_back(it);
    end
    it.data = 24'hABCDEF;
    it.sof  = 1'b1;
    src_q.push_back(it);
    for (int i = 0; i < 11; i++) begin
      it.data = 24'($urandom);
      it.sof  = 1'b0;
      src_q.push_back(it);
    end
    run(slot_cyc(1, 0, 0) + 1);
    checks++;
    if ({vga_r, vga_g, vga_b, vga_blank_n} !== {24'hABCDEF, 1'b1}) begin
      errors++;
      $display("FAIL sync_drop_origin got rgb=%h blank_n=%b want rgb=abcdef blank_n=1",
               {vga_r, vga_g, vga_b}, vga_blank_n);
    end
    run(40);
  endtask

  task automatic test_reset_mid();
    start_stream();
    push_frame(1'b1, 24'h0, -1);
    push_frame(1'b1, 24'h0, -1);
    push_frame(1'b1, 24'h0, -1);
    run(FRAME_CYC + 23);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_pins("reset_mid");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    src_q.delete();
    model_init();
    push_frame(1'b1, 24'h0, -1);
    run(FRAME_CYC);
  endtask

  task automatic test_enable();
    start_stream();
    push_frame(1'b1, 24'h0, -1);
    push_frame(1'b1, 24'h0, -1);
    push_frame(1'b1, 24'h0, -1);
    run(FRAME_CYC + 31);
    enable    = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    check_idle_pins("enable_off");
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL disabled_drop got=%b want=1", pix_ready);
    end
    pix_sof = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL disabled_sof_hold got=%b want=0", pix_ready);
    end
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    src_q.delete();
    enable = 1'b1;
    model_init();
    push_frame(1'b1, 24'h0, -1);
    run(FRAME_CYC);
  endtask

  task automatic test_random();
    start_stream();
    bubbles = 1'b1;
    for (int f = 0; f < 4; f++) push_frame(1'b1, 24'h0, -1);
    gap_lo = slot_cyc(1, $urandom_range(0, H_ACTIVE - 1), $urandom_range(0, V_ACTIVE - 1));
    gap_hi = gap_lo + 1;
    run(4 * FRAME_CYC);
    checks++;
    if ({underflow_cnt, frame_cnt} !== {16'd1, 16'd4}) begin
      errors++;
      $display("FAIL random_status got uf=%0d fc=%0d want uf=1 fc=4", underflow_cnt, frame_cnt);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    gap_lo    = -1;
    gap_hi    = -1;
    bubbles   = 1'b0;
    model_init();
    test_reset();
    test_timing();
    test_normal_frame();
    test_underflow();
    test_misalign();
    test_sync_drop();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
